// File: rtl/sat_bin_pkg.sv
// ---------------------------------------------------------------------------
// sat_bin_pkg
// Shared definitions for the SAT engine bin scheduler:
//   - state_t : scheduler FSM states
//   - mode_t  : what STORE hands over to next (advance to the next bin or
//               run a global backtrack)
//   - DEF_WIDTH_* : default widths for levels, bin indices and counters
// ---------------------------------------------------------------------------
package sat_bin_pkg;

  localparam int DEF_WIDTH_LVL = 16;
  localparam int DEF_WIDTH_BIN = 16;
  localparam int DEF_WIDTH_CNT = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_CORE      = 3'd2,
    ST_WAIT_CORE = 3'd3,
    ST_STORE     = 3'd4,
    ST_BKT       = 3'd5,
    ST_SAT       = 3'd6,
    ST_UNSAT     = 3'd7
  } state_t;

  typedef enum logic {
    MODE_ADVANCE   = 1'b0,
    MODE_BACKTRACK = 1'b1
  } mode_t;

endpackage

// File: rtl/sched_req_pulse.sv
// ---------------------------------------------------------------------------
// sched_req_pulse
// Turns "the scheduler is in state X" into a registered one-cycle request
// issued in the cycle after the state is entered.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   active   : scheduler currently sits in the requesting state
//   req      : one-cycle request pulse (registered)
//   issued   : the state was already active last cycle, i.e. the request
//              is being or has been issued during this visit
// ---------------------------------------------------------------------------
module sched_req_pulse (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic req,
  output logic issued
);

  // issued remembers the previous cycle's state membership; a rising edge of
  // active therefore produces exactly one req cycle per visit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued <= 1'b0;
      req    <= 1'b0;
    end else begin
      issued <= active;
      req    <= active & ~issued;
    end
  end

endmodule

// File: rtl/ctrl_bin_sched.sv
// ---------------------------------------------------------------------------
// ctrl_bin_sched
// Top-level bin scheduler of the SAT engine. Walks over all bins of a
// problem: load bin, run the core, store results, then advance to the next
// bin or perform a global backtrack. Reports global SAT/UNSAT.
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   start_i, num_bins_i            : solve request and bin count
//   done_o, global_sat_o,
//   global_unsat_o, error_o        : sticky result flags
//   cur_bin_num_o                  : bin currently scheduled
//   start_load_o / done_load_i     : bin load handshake
//   start_core_o / done_core_i,
//   core_sat_i, core_unsat_i,
//   bkt_bin_num_i, bkt_lvl_i       : per-bin core handshake and result
//   start_store_o / done_store_i   : store-back handshake
//   start_bkt_global_o, bkt_lvl_o,
//   done_bkt_global_i              : global backtrack handshake
//   bin_switch_cnt_o               : LOAD entries since last start
// ---------------------------------------------------------------------------
module ctrl_bin_sched
  import sat_bin_pkg::*;
#(
  parameter int WIDTH_LVL = DEF_WIDTH_LVL,
  parameter int WIDTH_BIN = DEF_WIDTH_BIN,
  parameter int WIDTH_CNT = DEF_WIDTH_CNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH_BIN-1:0] num_bins_i,
  output logic                 done_o,
  output logic                 global_sat_o,
  output logic                 global_unsat_o,
  output logic                 error_o,
  output logic [WIDTH_BIN-1:0] cur_bin_num_o,
  output logic                 start_load_o,
  input  logic                 done_load_i,
  output logic                 start_core_o,
  input  logic                 done_core_i,
  input  logic                 core_sat_i,
  input  logic                 core_unsat_i,
  input  logic [WIDTH_BIN-1:0] bkt_bin_num_i,
  input  logic [WIDTH_LVL-1:0] bkt_lvl_i,
  output logic                 start_store_o,
  input  logic                 done_store_i,
  output logic                 start_bkt_global_o,
  output logic [WIDTH_LVL-1:0] bkt_lvl_o,
  input  logic                 done_bkt_global_i,
  output logic [WIDTH_CNT-1:0] bin_switch_cnt_o
);

  state_t               state, state_nxt;
  mode_t                mode_q, mode_nxt;
  logic [WIDTH_BIN-1:0] num_bins_q, num_bins_nxt;
  logic [WIDTH_BIN-1:0] bkt_bin_q, bkt_bin_nxt;
  logic [WIDTH_BIN-1:0] cur_bin_nxt;
  logic [WIDTH_LVL-1:0] bkt_lvl_nxt;
  logic [WIDTH_CNT-1:0] cnt_nxt;
  logic                 done_nxt, sat_nxt, unsat_nxt, err_nxt;

  logic load_issued, core_issued, store_issued, bkt_issued;
  logic bkt_bad, last_bin;

  // A backtrack target outside the problem is a protocol error, not a pulse.
  assign bkt_bad  = (bkt_bin_q >= num_bins_q);
  assign last_bin = (cur_bin_num_o == num_bins_q - WIDTH_BIN'(1));

  sched_req_pulse u_load_req (
    .clk(clk), .rst(rst), .active(state == ST_LOAD),
    .req(start_load_o), .issued(load_issued)
  );

  sched_req_pulse u_core_req (
    .clk(clk), .rst(rst), .active(state == ST_CORE),
    .req(start_core_o), .issued(core_issued)
  );

  sched_req_pulse u_store_req (
    .clk(clk), .rst(rst), .active(state == ST_STORE),
    .req(start_store_o), .issued(store_issued)
  );

  sched_req_pulse u_bkt_req (
    .clk(clk), .rst(rst), .active((state == ST_BKT) && !bkt_bad),
    .req(start_bkt_global_o), .issued(bkt_issued)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // done_* only counts once the request went out and the pulse cycle is over.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (start_i) state_nxt = (num_bins_i == '0) ? ST_SAT : ST_LOAD;
      ST_LOAD:
        if (load_issued && !start_load_o && done_load_i) state_nxt = ST_CORE;
      ST_CORE:
        if (core_issued) state_nxt = ST_WAIT_CORE;
      ST_WAIT_CORE:
        if (done_core_i) begin
          if (core_unsat_i)    state_nxt = (bkt_lvl_i == '0) ? ST_UNSAT : ST_STORE;
          else if (core_sat_i) state_nxt = ST_STORE;
        end
      ST_STORE:
        if (store_issued && !start_store_o && done_store_i) begin
          if (mode_q == MODE_BACKTRACK) state_nxt = ST_BKT;
          else if (last_bin)            state_nxt = ST_SAT;
          else                          state_nxt = ST_LOAD;
        end
      ST_BKT:
        if (bkt_bad) state_nxt = ST_UNSAT;
        else if (bkt_issued && !start_bkt_global_o && done_bkt_global_i)
          state_nxt = ST_LOAD;
      ST_SAT:   state_nxt = ST_IDLE;
      ST_UNSAT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next values for all registered outputs and internal latches.
  always_comb begin
    done_nxt     = done_o;
    sat_nxt      = global_sat_o;
    unsat_nxt    = global_unsat_o;
    err_nxt      = error_o;
    cnt_nxt      = bin_switch_cnt_o;
    cur_bin_nxt  = cur_bin_num_o;
    num_bins_nxt = num_bins_q;
    bkt_bin_nxt  = bkt_bin_q;
    bkt_lvl_nxt  = bkt_lvl_o;
    mode_nxt     = mode_q;
    case (state)
      ST_IDLE:
        if (start_i) begin
          done_nxt     = 1'b0;
          sat_nxt      = 1'b0;
          unsat_nxt    = 1'b0;
          err_nxt      = 1'b0;
          cnt_nxt      = '0;
          num_bins_nxt = num_bins_i;
          cur_bin_nxt  = '0;
        end
      ST_WAIT_CORE:
        if (done_core_i) begin
          if (core_unsat_i) begin
            if (bkt_lvl_i != '0) begin
              bkt_bin_nxt = bkt_bin_num_i;
              bkt_lvl_nxt = bkt_lvl_i;
              mode_nxt    = MODE_BACKTRACK;
            end
          end else if (core_sat_i) begin
            mode_nxt = MODE_ADVANCE;
          end
        end
      ST_STORE:
        if (state_nxt == ST_LOAD) cur_bin_nxt = cur_bin_num_o + WIDTH_BIN'(1);
      ST_BKT:
        if (bkt_bad)                   err_nxt     = 1'b1;
        else if (state_nxt == ST_LOAD) cur_bin_nxt = bkt_bin_q;
      ST_SAT: begin
        sat_nxt  = 1'b1;
        done_nxt = 1'b1;
      end
      ST_UNSAT: begin
        unsat_nxt = 1'b1;
        done_nxt  = 1'b1;
      end
      default: ;
    endcase
    // Counted after the start clear so the first LOAD entry yields 1.
    if ((state_nxt == ST_LOAD) && (state != ST_LOAD) && (cnt_nxt != '1))
      cnt_nxt = cnt_nxt + WIDTH_CNT'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_o           <= 1'b0;
      global_sat_o     <= 1'b0;
      global_unsat_o   <= 1'b0;
      error_o          <= 1'b0;
      bin_switch_cnt_o <= '0;
      cur_bin_num_o    <= '0;
      num_bins_q       <= '0;
      bkt_bin_q        <= '0;
      bkt_lvl_o        <= '0;
      mode_q           <= MODE_ADVANCE;
    end else begin
      done_o           <= done_nxt;
      global_sat_o     <= sat_nxt;
      global_unsat_o   <= unsat_nxt;
      error_o          <= err_nxt;
      bin_switch_cnt_o <= cnt_nxt;
      cur_bin_num_o    <= cur_bin_nxt;
      num_bins_q       <= num_bins_nxt;
      bkt_bin_q        <= bkt_bin_nxt;
      bkt_lvl_o        <= bkt_lvl_nxt;
      mode_q           <= mode_nxt;
    end
  end

endmodule

// File: tb/tb_ctrl_bin_sched.sv
// ---------------------------------------------------------------------------
// tb_ctrl_bin_sched
// Directed bench for ctrl_bin_sched. A responder process plays the load,
// core, store and global backtrack units; the core answers from a small
// per-test script. Expected values are hand-computed per scenario.
// ---------------------------------------------------------------------------
module tb_ctrl_bin_sched;

  localparam int WL = 16;
  localparam int WB = 16;
  localparam int WC = 32;
  localparam int TIMEOUT = 400;

  logic          clk, rst, start_i;
  logic [WB-1:0] num_bins_i;
  logic          done_o, global_sat_o, global_unsat_o, error_o;
  logic [WB-1:0] cur_bin_num_o;
  logic          start_load_o, done_load_i;
  logic          start_core_o, done_core_i, core_sat_i, core_unsat_i;
  logic [WB-1:0] bkt_bin_num_i;
  logic [WL-1:0] bkt_lvl_i;
  logic          start_store_o, done_store_i;
  logic          start_bkt_global_o, done_bkt_global_i;
  logic [WL-1:0] bkt_lvl_o;
  logic [WC-1:0] bin_switch_cnt_o;

  int num_checks = 0;
  int num_fails  = 0;

  // Responder bookkeeping
  int            load_cnt, core_cnt, store_cnt, bkt_cnt;
  int            stores_at_bkt, width_viol, core_idx, scr_len;
  logic [WL-1:0] lvl_at_bkt;
  logic [WB-1:0] load_bins[$];
  bit            core_hold, core_pending;
  int            load_dly, store_dly, bkt_dly;
  bit            prev_load, prev_core, prev_store, prev_bkt;
  bit            scr_sat[4], scr_unsat[4];
  logic [WB-1:0] scr_bin[4];
  logic [WL-1:0] scr_lvl[4];

  ctrl_bin_sched #(.WIDTH_LVL(WL), .WIDTH_BIN(WB), .WIDTH_CNT(WC)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .num_bins_i(num_bins_i),
    .done_o(done_o), .global_sat_o(global_sat_o),
    .global_unsat_o(global_unsat_o), .error_o(error_o),
    .cur_bin_num_o(cur_bin_num_o),
    .start_load_o(start_load_o), .done_load_i(done_load_i),
    .start_core_o(start_core_o), .done_core_i(done_core_i),
    .core_sat_i(core_sat_i), .core_unsat_i(core_unsat_i),
    .bkt_bin_num_i(bkt_bin_num_i), .bkt_lvl_i(bkt_lvl_i),
    .start_store_o(start_store_o), .done_store_i(done_store_i),
    .start_bkt_global_o(start_bkt_global_o), .bkt_lvl_o(bkt_lvl_o),
    .done_bkt_global_i(done_bkt_global_i),
    .bin_switch_cnt_o(bin_switch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Units answer one cycle after seeing a request; dones last one cycle.
  initial begin
    load_dly = -1; store_dly = -1; bkt_dly = -1;
    forever begin
      @(negedge clk);
      done_load_i = 1'b0; done_store_i = 1'b0; done_bkt_global_i = 1'b0;
      done_core_i = 1'b0; core_sat_i = 1'b0; core_unsat_i = 1'b0;
      if (!rst) begin
        load_dly = -1; store_dly = -1; bkt_dly = -1; core_pending = 1'b0;
        prev_load = 1'b0; prev_core = 1'b0; prev_store = 1'b0; prev_bkt = 1'b0;
        continue;
      end
      if ((start_load_o && prev_load) || (start_core_o && prev_core) ||
          (start_store_o && prev_store) || (start_bkt_global_o && prev_bkt))
        width_viol++;
      prev_load = start_load_o; prev_core = start_core_o;
      prev_store = start_store_o; prev_bkt = start_bkt_global_o;
      if (load_dly == 0)  begin done_load_i = 1'b1;       load_dly = -1;  end
      if (store_dly == 0) begin done_store_i = 1'b1;      store_dly = -1; end
      if (bkt_dly == 0)   begin done_bkt_global_i = 1'b1; bkt_dly = -1;   end
      if (core_pending && !core_hold) begin
        done_core_i = 1'b1;
        if (core_idx < scr_len) begin
          core_sat_i = scr_sat[core_idx]; core_unsat_i = scr_unsat[core_idx];
          bkt_bin_num_i = scr_bin[core_idx]; bkt_lvl_i = scr_lvl[core_idx];
        end else begin
          core_sat_i = 1'b1; bkt_bin_num_i = '0; bkt_lvl_i = '0;
        end
        core_idx++;
        core_pending = 1'b0;
      end
      if (start_load_o)  begin load_cnt++; load_bins.push_back(cur_bin_num_o); load_dly = 0; end
      if (start_store_o) begin store_cnt++; store_dly = 0; end
      if (start_core_o)  begin core_cnt++; core_pending = 1'b1; end
      if (start_bkt_global_o) begin
        bkt_cnt++; stores_at_bkt = store_cnt; lvl_at_bkt = bkt_lvl_o; bkt_dly = 0;
      end
    end
  end

  task automatic clearCounts();
    load_cnt = 0; core_cnt = 0; store_cnt = 0; bkt_cnt = 0;
    stores_at_bkt = 0; lvl_at_bkt = '0; core_idx = 0; scr_len = 0;
    load_bins.delete();
  endtask

  // Pulses start_i for one cycle; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [WB-1:0] nb);
    @(negedge clk);
    clearCounts();
    num_bins_i = nb;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    for (int i = 0; i < TIMEOUT && !done_o; i++) @(negedge clk);
    checkOutput({tag, "_done"}, done_o, 1);
  endtask

  initial begin
    logic [WB-1:0] exp_bins[5];
    rst = 1'b0; start_i = 1'b0; num_bins_i = '0; core_hold = 1'b0; width_viol = 0;
    clearCounts();
    #2;
    checkOutput("rst_flags", {done_o, global_sat_o, global_unsat_o, error_o}, 0);
    checkOutput("rst_pulses", {start_load_o, start_core_o, start_store_o, start_bkt_global_o}, 0);
    checkOutput("rst_cnt", bin_switch_cnt_o, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    $display("[TB] Test 1: three bins, all sat");
    applyStimulus(3);
    checkOutput("t1_load_n", start_load_o, 0);
    checkOutput("t1_cur_bin", cur_bin_num_o, 0);
    checkOutput("t1_cnt_entry", bin_switch_cnt_o, 1);
    @(negedge clk);
    checkOutput("t1_load_n1", start_load_o, 1);
    @(negedge clk);
    checkOutput("t1_load_n2", start_load_o, 0);
    waitDone("t1");
    checkOutput("t1_sat", {global_sat_o, global_unsat_o, error_o}, 3'b100);
    checkOutput("t1_cnt", bin_switch_cnt_o, 3);
    checkOutput("t1_loads", load_cnt, 3);
    checkOutput("t1_cores", core_cnt, 3);
    checkOutput("t1_stores", store_cnt, 3);
    checkOutput("t1_bkts", bkt_cnt, 0);
    exp_bins = '{0, 1, 2, 0, 0};
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("t1_bin%0d", i), (i < load_bins.size()) ? load_bins[i] : 16'hFFFF, exp_bins[i]);

    $display("[TB] Test 2: zero bins");
    applyStimulus(0);
    checkOutput("t2_done_clr", done_o, 0);
    for (int i = 0; i < 2 && !done_o; i++) @(negedge clk);
    checkOutput("t2_done", done_o, 1);
    checkOutput("t2_sat", global_sat_o, 1);
    checkOutput("t2_pulses", load_cnt + core_cnt + store_cnt, 0);
    checkOutput("t2_cnt", bin_switch_cnt_o, 0);

    $display("[TB] Test 3: backtrack from bin 1 to bin 0");
    applyStimulus(3);
    scr_len = 2;
    scr_sat[0] = 1; scr_unsat[0] = 0; scr_bin[0] = 0; scr_lvl[0] = 0;
    scr_sat[1] = 0; scr_unsat[1] = 1; scr_bin[1] = 0; scr_lvl[1] = 2;
    checkOutput("t3_done_clr", done_o, 0);
    waitDone("t3");
    checkOutput("t3_sat", {global_sat_o, global_unsat_o, error_o}, 3'b100);
    checkOutput("t3_cnt", bin_switch_cnt_o, 5);
    checkOutput("t3_bkts", bkt_cnt, 1);
    checkOutput("t3_bkt_lvl", lvl_at_bkt, 2);
    checkOutput("t3_store_before_bkt", stores_at_bkt, 2);
    checkOutput("t3_stores", store_cnt, 5);
    exp_bins = '{0, 1, 0, 1, 2};
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("t3_bin%0d", i), (i < load_bins.size()) ? load_bins[i] : 16'hFFFF, exp_bins[i]);

    $display("[TB] Test 4: unsat at level 0");
    applyStimulus(2);
    scr_len = 1;
    scr_sat[0] = 0; scr_unsat[0] = 1; scr_bin[0] = 0; scr_lvl[0] = 0;
    waitDone("t4");
    checkOutput("t4_unsat", {global_sat_o, global_unsat_o, error_o}, 3'b010);
    checkOutput("t4_stores", store_cnt, 0);
    checkOutput("t4_bkts", bkt_cnt, 0);
    checkOutput("t4_loads", load_cnt, 1);

    $display("[TB] Test 5: illegal backtrack bin");
    applyStimulus(3);
    scr_len = 1;
    scr_sat[0] = 1; scr_unsat[0] = 1; scr_bin[0] = 5; scr_lvl[0] = 1;
    waitDone("t5");
    checkOutput("t5_err", {global_sat_o, global_unsat_o, error_o}, 3'b011);
    checkOutput("t5_stores", store_cnt, 1);
    checkOutput("t5_bkts", bkt_cnt, 0);
    checkOutput("t5_lvl", bkt_lvl_o, 1);

    $display("[TB] Test 6: start during WAIT_CORE, reset during LOAD");
    core_hold = 1'b1;
    applyStimulus(3);
    for (int i = 0; i < TIMEOUT && !start_core_o; i++) @(negedge clk);
    checkOutput("t6_core_seen", start_core_o, 1);
    @(negedge clk);
    num_bins_i = 7;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    checkOutput("t6_cur_bin_hold", cur_bin_num_o, 0);
    checkOutput("t6_cnt_hold", bin_switch_cnt_o, 1);
    checkOutput("t6_load_hold", load_cnt, 1);
    core_hold = 1'b0;
    for (int i = 0; i < TIMEOUT && !(start_load_o && cur_bin_num_o == 1); i++) @(negedge clk);
    checkOutput("t6_load1_seen", {start_load_o, cur_bin_num_o}, {1'b1, 16'd1});
    checkOutput("t6_cnt_pre", bin_switch_cnt_o, 2);
    #1 rst = 1'b0;
    #1;
    checkOutput("t6_rst_pulses", {start_load_o, start_core_o, start_store_o, start_bkt_global_o}, 0);
    checkOutput("t6_rst_flags", {done_o, global_sat_o, global_unsat_o, error_o}, 0);
    checkOutput("t6_rst_cur_bin", cur_bin_num_o, 0);
    checkOutput("t6_rst_cnt", bin_switch_cnt_o, 0);
    checkOutput("t6_rst_lvl", bkt_lvl_o, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    checkOutput("pulse_width", width_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/ctrl_bin_sched.md
Name: ctrl_bin_sched

Overview:
- Top-level bin scheduler for the SAT engine.
- Sequences the per-bin flow over all bins of a problem: load bin, start core, store results, then advance or do a global backtrack.
- Sits above the per-bin core controller and the bin load/store and global backtrack units.
- Reports global SAT/UNSAT.

Parameters:
- WIDTH_LVL, 16, width of decision-level values.
- WIDTH_BIN, 16, width of bin indices and bin count.
- WIDTH_CNT, 32, width of the bin-switch statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start_i  in  1  start solve; sampled only in IDLE
- num_bins_i  in  WIDTH_BIN  number of bins; latched on accepted start_i
- done_o  out  1  sticky solve-complete flag
- global_sat_o  out  1  sticky SAT result
- global_unsat_o  out  1  sticky UNSAT result
- error_o  out  1  sticky protocol error (illegal backtrack bin)
- cur_bin_num_o  out  WIDTH_BIN  bin currently scheduled
- start_load_o  out  1  one-cycle load request for cur_bin_num_o
- done_load_i  in  1  load finished
- start_core_o  out  1  one-cycle core start pulse
- done_core_i  in  1  core finished
- core_sat_i  in  1  core result: partial SAT, valid with done_core_i
- core_unsat_i  in  1  core result: partial UNSAT, valid with done_core_i
- bkt_bin_num_i  in  WIDTH_BIN  backtrack target bin, valid with done_core_i
- bkt_lvl_i  in  WIDTH_LVL  backtrack target level, valid with done_core_i
- start_store_o  out  1  one-cycle store-back request
- done_store_i  in  1  store finished
- start_bkt_global_o  out  1  one-cycle global backtrack request
- bkt_lvl_o  out  WIDTH_LVL  latched backtrack level, stable from pulse until done
- done_bkt_global_i  in  1  global backtrack finished
- bin_switch_cnt_o  out  WIDTH_CNT  number of LOAD entries since last start

Behaviour:
Reset and general rules
- Reset (rst low, asynchronous) forces: state IDLE, every output 0, internal latches 0. Applies immediately, including mid-operation.
- All outputs are registered.
- Each start_* request is exactly one cycle high. It is asserted in the first cycle after entering its state.
- done_* inputs are ignored in the pulse cycle and in any state that is not waiting on them.

States
- IDLE
  - start_i=1: clear done/sat/unsat/error flags and the counter; latch num_bins_i.
  - If num_bins_i==0, go to SAT. Otherwise set cur_bin=0 and go to LOAD.
  - start_i in any other state is ignored.
- LOAD
  - On entry, increment bin_switch_cnt_o, saturating at all-ones.
  - Pulse start_load_o.
  - done_load_i → CORE.
- CORE
  - Pulse start_core_o, then move to WAIT_CORE the next cycle.
- WAIT_CORE (on done_core_i)
  - core_unsat_i=1 (has priority over core_sat_i):
    - If bkt_lvl_i==0 → UNSAT, with no store.
    - Otherwise latch bkt_bin_num_i and bkt_lvl_i, set mode=BACKTRACK, go to STORE.
  - core_sat_i=1 only: set mode=ADVANCE, go to STORE.
  - Neither set: done_core_i is ignored; stay in WAIT_CORE.
- STORE
  - Pulse start_store_o.
  - On done_store_i with mode ADVANCE:
    - cur_bin==num_bins-1 → SAT.
    - Otherwise cur_bin+1 → LOAD.
  - On done_store_i with mode BACKTRACK → BKT.
- BKT
  - If the latched bkt_bin_num >= num_bins: set error_o and go to UNSAT, with no pulse.
  - Otherwise pulse start_bkt_global_o, driving bkt_lvl_o.
  - done_bkt_global_i: cur_bin = latched bkt bin → LOAD.
- SAT: set global_sat_o and done_o → IDLE.
- UNSAT: set global_unsat_o and done_o → IDLE.

Timing
- An accepted start_i at edge N enters LOAD at N+1. start_load_o is high for cycle N+2 only.
- cur_bin_num_o changes only on LOAD entry and on start.
- Result flags hold until the next accepted start_i or reset.

Decomposition:
- Shared package sat_bin_pkg holds:
  - state encoding (IDLE, LOAD, CORE, WAIT_CORE, STORE, BKT, SAT, UNSAT);
  - mode constants ADVANCE/BACKTRACK;
  - width defaults.
- Sub-module sched_req_pulse: generates a one-cycle registered request on state entry. Instantiated four times (load, core, store, bkt).

Test Plan:
1. num_bins=3, core always returns sat.
   - Required: loads bins 0,1,2; 3 store pulses; global_sat_o=1, done_o=1; bin_switch_cnt_o=3; no bkt pulse.
2. num_bins=0.
   - Required: done_o and global_sat_o high within 3 cycles; zero load/core/store pulses.
3. Bin 0 sat; bin 1 unsat with bkt_bin_num=0, bkt_lvl=2; then all sat.
   - Required: store, then start_bkt_global_o with bkt_lvl_o=2; reload bin 0; then bins 1,2; global_sat_o=1; bin_switch_cnt_o=5.
4. Bin 0 unsat with bkt_lvl_i=0.
   - Required: global_unsat_o=1 and done_o=1; no store and no bkt pulse.
5. num_bins=3; bin 0 unsat with bkt_bin_num_i=5, lvl=1.
   - Required: store pulse, then error_o=1 and global_unsat_o=1; no bkt pulse.
6. Drive rst low while in LOAD, and pulse start_i during WAIT_CORE.
   - Required: all outputs 0 with no wait for a clock edge.
   - Required: start_i during WAIT_CORE does not change cur_bin_num_o or the counter.
